// File: rtl/congestion_detector.sv
// congestion_detector
// Estimates the main-road vehicle queue from arrival pulses and a fixed-rate
// drain that runs while the main road is GO / GO-ATTENTION.  It raises a
// congestion request for the traffic-light controller. The request is raised
// only after the queue has stayed high for several samples, and it is held
// until the queue falls to the low threshold (hysteresis).
module congestion_detector #(
  parameter int HIGH_TH   = 12,
  parameter int LOW_TH    = 4,
  parameter int QMAX      = 31,
  parameter int CNT_W     = 5,
  parameter int DRAIN_PER = 2,
  parameter int CONFIRM   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             car_in,
  input  logic [1:0]       main_state,
  output logic             cong,
  output logic [CNT_W-1:0] queue,
  output logic             overflow
);

  // Widths of the internal counters.  The drain timer needs at least one bit
  // even when DRAIN_PER is 1.
  localparam int DRAIN_W = (DRAIN_PER > 1) ? $clog2(DRAIN_PER) : 1;
  localparam int CONF_W  = (CONFIRM > 1) ? $clog2(CONFIRM) : 1;

  localparam logic [CNT_W-1:0]   HIGH_Q     = CNT_W'(HIGH_TH);
  localparam logic [CNT_W-1:0]   LOW_Q      = CNT_W'(LOW_TH);
  localparam logic [CNT_W-1:0]   QMAX_Q     = CNT_W'(QMAX);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_PER - 1);
  localparam logic [CONF_W-1:0]  CONF_LOAD  = CONF_W'(CONFIRM - 1);
  localparam logic [CONF_W-1:0]  CONF_ONE   = CONF_W'(1);

  typedef enum logic [1:0] {
    CLEAR   = 2'd0,
    PENDING = 2'd1,
    CONG    = 2'd2
  } cong_state_t;

  logic [DRAIN_W-1:0] drain_cnt;
  logic [CONF_W-1:0]  conf_cnt;
  logic [CONF_W-1:0]  conf_cnt_next;
  cong_state_t        state;
  cong_state_t        state_next;

  logic go;
  logic drain_wrap;
  logic arr;
  logic dep;

  // Main road is draining in GO (2) and GO-ATTENTION (3).
  assign go         = (main_state == 2'd2) || (main_state == 2'd3);
  assign drain_wrap = (drain_cnt == DRAIN_LAST);
  assign arr        = car_in;
  assign dep        = go && drain_wrap && (queue != '0);

  // Drain timer: runs freely through a GO phase and restarts whenever the main road stops.
  always_ff @(posedge clk) begin
    if (rst) begin
      drain_cnt <= '0;
    end else if (!go) begin
      drain_cnt <= '0;
    end else if (drain_wrap) begin
      drain_cnt <= '0;
    end else begin
      drain_cnt <= drain_cnt + DRAIN_W'(1);
    end
  end

  // Queue estimate: saturating counter.  An arrival and a departure on the same edge cancel.
  always_ff @(posedge clk) begin
    if (rst) begin
      queue    <= '0;
      overflow <= 1'b0;
    end else if (arr && !dep) begin
      if (queue == QMAX_Q) begin
        overflow <= 1'b1;
      end else begin
        queue <= queue + CNT_W'(1);
      end
    end else if (!arr && dep) begin
      queue <= queue - CNT_W'(1);
    end
  end

  // Congestion FSM state and confirmation counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= CLEAR;
      conf_cnt <= '0;
    end else begin
      state    <= state_next;
      conf_cnt <= conf_cnt_next;
    end
  end

  // Next-state logic, driven by the queue value registered before this edge.
  always_comb begin
    state_next    = state;
    conf_cnt_next = conf_cnt;
    unique case (state)
      CLEAR: begin
        if (queue >= HIGH_Q) begin
          state_next    = PENDING;
          conf_cnt_next = CONF_LOAD;
        end
      end
      PENDING: begin
        if (queue < HIGH_Q) begin
          state_next = CLEAR;
        end else if (conf_cnt == CONF_ONE) begin
          state_next = CONG;
        end else begin
          conf_cnt_next = conf_cnt - CONF_W'(1);
        end
      end
      CONG: begin
        if (queue <= LOW_Q) begin
          state_next = CLEAR;
        end
      end
      default: begin
        state_next = CLEAR;
      end
    endcase
  end

  // Output decode of the registered state.
  always_comb begin
    cong = (state == CONG);
  end

endmodule
